// File: rtl/bit_serial_adder_pkg.sv
// Shared ALU definitions: serial-adder state encoding and add/sub opcode values.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Purely combinational one-bit full-adder cell shared by the serial ALU path.
module one_bit_adder (
    input  logic cin,
    input  logic in0,
    input  logic in1,
    output logic out,
    output logic cout
);

    assign out  = in0 ^ in1 ^ cin;
    assign cout = (in0 & in1) | (cin & (in0 ^ in1));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial add/subtract: one operand bit per clock through a single full-adder,
// with carry held in a flop; result, carry-out and signed overflow presented with a done pulse.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_out;
    logic             fa_cout;
    logic             last_bit;
    logic             is_sub;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign is_sub   = (sub == ALU_OP_SUB);

    one_bit_adder u_fa (
        .cin  (carry),
        .in0  (a_sr[0]),
        .in1  (b_sr[0]),
        .out  (fa_out),
        .cout (fa_cout)
    );

    // Subtraction is a + ~b + 1: invert B on accept and seed the carry with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{is_sub}};
                        carry <= is_sub;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= fa_cout;
                    sum   <= {fa_out, sum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    if (last_bit) begin
                        cnt      <= '0;
                        cout     <= fa_cout;
                        overflow <= carry ^ fa_cout;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: WIDTH=8 and WIDTH=32 instances checked every cycle against an
// operation-level reference model, plus directed cases with literal expectations.
module tb_bit_serial_adder;

    localparam int unsigned W0 = 8;
    localparam int unsigned W1 = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start8, sub8, busy8, done8, cout8, ovf8;
    logic [W0-1:0] a8, b8, sum8;
    logic          start32, sub32, busy32, done32, cout32, ovf32;
    logic [W1-1:0] a32, b32, sum32;

    bit_serial_adder #(.WIDTH(W0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    bit_serial_adder #(.WIDTH(W1)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference arithmetic on whole words: unsigned carry/borrow and signed-range overflow.
    function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic s, output logic [63:0] r, output logic c,
                                   output logic v);
        logic [63:0] m, ua, ub;
        logic [64:0] full;
        logic        sa, sb;
        m  = width_mask(w);
        ua = a & m;
        ub = b & m;
        sa = ua[w-1];
        sb = ub[w-1];
        if (!s) begin
            full = {1'b0, ua} + {1'b0, ub};
            r    = full[63:0] & m;
            c    = full[w];
            v    = (sa == sb) && (r[w-1] != sa);
        end else begin
            r = (ua - ub) & m;
            c = (ua >= ub);
            v = (sa != sb) && (r[w-1] != sa);
        end
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        m = width_mask(w);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {32'($urandom), 32'($urandom)} & m;
        endcase
    endfunction

    // Model: age = edges since an operation was accepted, -1 when idle.
    int          m_age  [2];
    logic [63:0] m_sum  [2];
    logic        m_cout [2];
    logic        m_ovf  [2];
    logic [63:0] p_sum  [2];
    logic        p_cout [2];
    logic        p_ovf  [2];
    int          ndone  [2];

    int          mw;
    logic        ms_st, ms_sb;
    logic [63:0] ms_a, ms_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_age[i]  = -1;
                m_sum[i]  = '0;
                m_cout[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mw    = (i == 0) ? W0 : W1;
                ms_st = (i == 0) ? start8 : start32;
                ms_sb = (i == 0) ? sub8 : sub32;
                ms_a  = (i == 0) ? 64'(a8) : 64'(a32);
                ms_b  = (i == 0) ? 64'(b8) : 64'(b32);
                if (m_age[i] < 0) begin
                    if (ms_st) begin
                        ref_op(mw, ms_a, ms_b, ms_sb, p_sum[i], p_cout[i], p_ovf[i]);
                        m_sum[i] = '0;
                        m_age[i] = 0;
                    end
                end else begin
                    m_age[i]++;
                    if (m_age[i] == mw) begin
                        m_sum[i]  = p_sum[i];
                        m_cout[i] = p_cout[i];
                        m_ovf[i]  = p_ovf[i];
                    end else if (m_age[i] == mw + 1) begin
                        m_age[i] = -1;
                    end
                end
            end
        end
    end

    int          cw;
    logic        c_busy, c_done, c_cout, c_ovf;
    logic [63:0] c_sum;

    // Compare every cycle on the falling edge; sum only while it is architecturally stable.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                cw     = (i == 0) ? W0 : W1;
                c_busy = (i == 0) ? busy8 : busy32;
                c_done = (i == 0) ? done8 : done32;
                c_cout = (i == 0) ? cout8 : cout32;
                c_ovf  = (i == 0) ? ovf8 : ovf32;
                c_sum  = (i == 0) ? 64'(sum8) : 64'(sum32);
                check($sformatf("w%0d busy", cw), 64'(c_busy),
                      64'((m_age[i] >= 0) && (m_age[i] < cw)));
                check($sformatf("w%0d done", cw), 64'(c_done), 64'(m_age[i] == cw));
                check($sformatf("w%0d cout", cw), 64'(c_cout), 64'(m_cout[i]));
                check($sformatf("w%0d overflow", cw), 64'(c_ovf), 64'(m_ovf[i]));
                if (m_age[i] < 0 || m_age[i] == cw)
                    check($sformatf("w%0d sum", cw), c_sum, m_sum[i]);
                if (c_done) ndone[i]++;
            end
        end
    end

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] es, input logic ec, input logic ev);
        int cyc, nb;
        bit got;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        cyc = 0; nb = 0; got = 1'b0;
        while (cyc < 50 && !got) begin
            @(negedge clk);
            start8 = 1'b0;
            cyc++;
            if (busy8) nb++;
            if (done8) got = 1'b1;
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'd9);
        check({name, " busy cycles"}, 64'(nb), 64'd8);
        check({name, " sum"}, 64'(sum8), 64'(es));
        check({name, " cout"}, 64'(cout8), 64'(ec));
        check({name, " overflow"}, 64'(ovf8), 64'(ev));
        check({name, " model sum"}, m_sum[0], 64'(es));
        @(negedge clk);
        check({name, " done one cycle"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int cyc, d, t1, t2;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset sum", 64'(sum8), 64'd0);
        check("reset cout", 64'(cout8), 64'd0);
        check("reset overflow", 64'(ovf8), 64'd0);
        check("reset sum32", 64'(sum32), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run8("add 35+0a", 8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0);
        run8("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("sub 05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run8("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        // Start held high with operands churning: first result reported, then 34-cycle spacing.
        @(negedge clk);
        a32 = 32'h12345678; b32 = 32'h00001111; sub32 = 1'b0; start32 = 1'b1;
        cyc = 0; d = 0; t1 = 0; t2 = 0;
        while (d < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                if (d == 0) begin
                    t1 = cyc;
                    check("held first sum", 64'(sum32), 64'h12346789);
                end else begin
                    t2 = cyc;
                end
                d++;
            end
            a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
        end
        start32 = 1'b0;
        check("held two dones", 64'(d), 64'd2);
        check("held first latency", 64'(t1), 64'd33);
        check("held done spacing", 64'(t2 - t1), 64'd34);

        // Async reset on the third processed bit of an 8-bit op.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", 64'(busy8), 64'd1);
        check("pre-reset cout", 64'(cout8), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid reset busy", 64'(busy8), 64'd0);
        check("mid reset done", 64'(done8), 64'd0);
        check("mid reset sum", 64'(sum8), 64'd0);
        check("mid reset cout", 64'(cout8), 64'd0);
        check("mid reset overflow", 64'(ovf8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run8("post-reset 01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Random regression on both widths concurrently; starts often land while busy.
        fork
            begin
                int c8, n8;
                c8 = 0; n8 = ndone[0];
                while (ndone[0] - n8 < 1000 && c8 < 30000) begin
                    @(negedge clk);
                    c8++;
                    start8 = ($urandom_range(0, 3) != 0);
                    sub8   = 1'($urandom);
                    a8     = 8'(pick(W0));
                    b8     = 8'(pick(W0));
                end
                start8 = 1'b0;
                check("w8 random ops completed", 64'(ndone[0] - n8 >= 1000), 64'd1);
            end
            begin
                int c32, n32;
                c32 = 0; n32 = ndone[1];
                while (ndone[1] - n32 < 1000 && c32 < 45000) begin
                    @(negedge clk);
                    c32++;
                    start32 = ($urandom_range(0, 3) != 0);
                    sub32   = 1'($urandom);
                    a32     = 32'(pick(W1));
                    b32     = 32'(pick(W1));
                end
                start32 = 1'b0;
                check("w32 random ops completed", 64'(ndone[1] - n32 >= 1000), 64'd1);
            end
        join
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
